// File: rtl/bch_enc_pkg.sv
// Shared constants, FSM state encoding and configuration check for the BCH encoder/decoder pair.
package bch_enc_pkg;

  localparam int N_MAX   = 1023;
  localparam int T_MAX   = 4;
  localparam int M_MAX   = 10;
  localparam int PAR_MAX = M_MAX * T_MAX;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MSG  = 2'd1,
    ST_PAR  = 2'd2
  } state_e;

  // A code is usable only if the field, parity length and generator constant term are consistent.
  function automatic logic bch_cfg_valid(
    input logic [9:0] n,
    input logic [3:0] t,
    input logic [3:0] m,
    input logic       g0
  );
    logic [7:0]  p;
    logic [15:0] n_lim;
    p     = {4'd0, m} * {4'd0, t};
    n_lim = (16'd1 << m) - 16'd1;
    return (m >= 4'd3) && (m <= 4'(M_MAX)) &&
           (t >= 4'd1) && (t <= 4'(T_MAX)) &&
           ({2'b00, p} < n) &&
           ({6'd0, n} <= n_lim) &&
           ({1'b0, n} <= 11'(N_MAX)) &&
           g0;
  endfunction

endpackage

// File: rtl/bch_par_lfsr.sv
// Masked generator-polynomial LFSR holding the running parity remainder for p active bits.
module bch_par_lfsr
  import bch_enc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift,
  input  logic               feed,
  input  logic               din,
  input  logic [7:0]         p,
  input  logic [PAR_MAX-1:0] g_poly,
  output logic               msb
);

  logic [PAR_MAX-1:0] r_q;
  logic [PAR_MAX-1:0] r_d;
  logic [PAR_MAX-1:0] mask;
  logic [PAR_MAX-1:0] top;
  logic               fb;

  always_comb begin
    mask = '0;
    for (int i = 0; i < PAR_MAX; i++) begin
      mask[i] = (8'(i) < p);
    end
  end

  // The highest set mask bit selects r[p-1] without a variable index.
  assign top = mask ^ (mask >> 1);
  assign msb = |(r_q & top);
  assign fb  = feed & (din ^ msb);

  always_comb begin
    r_d = r_q;
    if (clr) begin
      r_d = '0;
    end else if (shift) begin
      r_d = ((r_q << 1) ^ (fb ? g_poly : '0)) & mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else begin
      r_q <= r_d;
    end
  end

endmodule

// File: rtl/bch_enc_core.sv
// Bit-serial systematic BCH encoder: message pass-through followed by LFSR parity, one bit per beat.
module bch_enc_core
  import bch_enc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [9:0]         n,
  input  logic [3:0]         t,
  input  logic [3:0]         m,
  input  logic [PAR_MAX-1:0] g_poly,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_bit,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_bit,
  output logic               out_last,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  state_e             state_q, state_d;
  logic [9:0]         cnt_q, cnt_d;
  logic [9:0]         k_q, k_d;
  logic [7:0]         p_q, p_d;
  logic [PAR_MAX-1:0] g_q, g_d;
  logic               done_q, done_d;
  logic               cfg_err_q, cfg_err_d;

  logic [7:0]         p_calc;
  logic [9:0]         p_ext;
  logic               lfsr_clr;
  logic               lfsr_shift;
  logic               lfsr_feed;
  logic               lfsr_msb;

  assign p_calc = {4'd0, m} * {4'd0, t};
  assign p_ext  = {2'b00, p_q};

  // Message bits pass straight through; parity comes from the LFSR once k bits have been accepted.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    p_d        = p_q;
    g_d        = g_q;
    done_d     = 1'b0;
    cfg_err_d  = cfg_err_q;
    lfsr_clr   = 1'b0;
    lfsr_shift = 1'b0;
    lfsr_feed  = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_bit    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (bch_cfg_valid(n, t, m, g_poly[0])) begin
            state_d   = ST_MSG;
            cnt_d     = '0;
            lfsr_clr  = 1'b1;
            cfg_err_d = 1'b0;
            p_d       = p_calc;
            k_d       = n - {2'b00, p_calc};
            g_d       = g_poly;
          end else begin
            done_d    = 1'b1;
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_MSG: begin
        out_valid = in_valid;
        in_ready  = out_ready;
        out_bit   = in_bit;
        if (in_valid && out_ready) begin
          lfsr_shift = 1'b1;
          lfsr_feed  = 1'b1;
          if (cnt_q == k_q - 10'd1) begin
            cnt_d   = '0;
            state_d = ST_PAR;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
      end
      ST_PAR: begin
        out_valid = 1'b1;
        out_bit   = lfsr_msb;
        if (out_ready) begin
          lfsr_shift = 1'b1;
          if (cnt_q == p_ext - 10'd1) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      k_q       <= '0;
      p_q       <= '0;
      g_q       <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      p_q       <= p_d;
      g_q       <= g_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign out_last = (state_q == ST_PAR) && (cnt_q == p_ext - 10'd1);
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign cfg_err  = cfg_err_q;

  bch_par_lfsr u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .clr    (lfsr_clr),
    .shift  (lfsr_shift),
    .feed   (lfsr_feed),
    .din    (in_bit),
    .p      (p_q),
    .g_poly (g_q),
    .msb    (lfsr_msb)
  );

endmodule

// File: tb/tb_bch_enc_core.sv
// Scoreboard bench for bch_enc_core: the driver queues expected codeword bits, the monitor checks each output beat.
module tb_bch_enc_core;
  import bch_enc_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [9:0]         n;
  logic [3:0]         t;
  logic [3:0]         m;
  logic [PAR_MAX-1:0] g_poly;
  logic               in_valid;
  logic               in_ready;
  logic               in_bit;
  logic               out_valid;
  logic               out_ready;
  logic               out_bit;
  logic               out_last;
  logic               busy;
  logic               done;
  logic               cfg_err;

  always #5 clk = ~clk;

  bch_enc_core dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .n         (n),
    .t         (t),
    .m         (m),
    .g_poly    (g_poly),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bit   (out_bit),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err)
  );

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t exp_q[$];
  logic got_bits[$];
  int   n_vec = 0;
  int   n_mis = 0;

  localparam logic [PAR_MAX-1:0] G_HAM   = 40'h3;
  localparam logic [PAR_MAX-1:0] G_63_51 = 40'h539;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_mis++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      got_bits.push_back(out_bit);
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_beat", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("cw_bit", 32'(out_bit), 32'(e.b));
        checkOutput("out_last", 32'(out_last), 32'(e.last));
      end
    end
  end

  // Index 0 is the first bit on the wire (highest degree).
  function automatic logic [1023:0] bits_from(input logic [63:0] val, input int len);
    logic [1023:0] v;
    v = '0;
    for (int i = 0; i < len; i++) v[i] = val[len-1-i];
    return v;
  endfunction

  // Long division by g(x) over GF(2); whatever survives in positions k..n-1 is the remainder.
  function automatic logic [1023:0] poly_reduce(input logic [1023:0] c, input int nn, input int pp,
                                                input logic [PAR_MAX-1:0] g);
    for (int i = 0; i + pp < nn; i++) begin
      if (c[i]) begin
        for (int j = 0; j <= pp; j++) begin
          if (j == pp || g[j]) c[i+pp-j] = ~c[i+pp-j];
        end
      end
    end
    return c;
  endfunction

  function automatic logic [1023:0] model_cw(input logic [1023:0] msg, input int nn, input int pp,
                                             input logic [PAR_MAX-1:0] g);
    return msg | poly_reduce(msg, nn, pp, g);
  endfunction

  // Runs one frame from posedge+1 back to posedge+1; rst_after >= 0 aborts with reset after that many parity beats.
  task automatic applyStimulus(input string tag, input logic [1023:0] msg, input int nn, input int mm,
                               input int tt, input logic [PAR_MAX-1:0] g, input logic [1023:0] exp_cw,
                               input bit stall, input bit poke_start, input int rst_after);
    int            pp;
    int            kk;
    int            idx;
    int            cyc;
    logic [1023:0] rx;
    logic [1023:0] rem;
    pp = mm * tt;
    kk = nn - pp;
    $display("[TB] frame %s n=%0d m=%0d t=%0d stall=%0d", tag, nn, mm, tt, stall);
    got_bits.delete();
    for (int i = 0; i < nn; i++) exp_q.push_back('{b: exp_cw[i], last: (i == nn - 1)});

    in_valid  = 1'b0;
    out_ready = 1'b1;
    start     = 1'b1;
    n         = 10'(nn);
    m         = 4'(mm);
    t         = 4'(tt);
    g_poly    = g;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("start_busy", 32'(busy), 32'd1);
    checkOutput("start_cfg_err", 32'(cfg_err), 32'd0);
    @(posedge clk); #1;

    idx = 0;
    cyc = 0;
    while (idx < kk && cyc < 4000) begin
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = stall ? (($urandom_range(0, 3)) != 0) : 1'b1;
      in_bit    = msg[idx];
      if (poke_start && idx == 2) begin
        start = 1'b1;
        n     = 10'd12;
        m     = 4'd6;
        t     = 4'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      checkOutput("msg_in_ready", 32'(in_ready), 32'(out_ready));
      if (in_valid && out_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    if (cyc >= 4000) checkOutput("msg_timeout", 32'd1, 32'd0);

    idx = 0;
    cyc = 0;
    while (idx < pp && cyc < 4000) begin
      if (idx == rst_after) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checkOutput("rst_outputs", 32'({in_ready, out_valid, out_bit, out_last, busy, done, cfg_err}), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("rst_no_done", 32'({busy, done}), 32'd0);
        @(posedge clk); #1;
        return;
      end
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      checkOutput("par_in_ready", 32'(in_ready), 32'd0);
      if (out_valid && out_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 4000) checkOutput("par_timeout", 32'd1, 32'd0);

    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("done_pulse", 32'({done, busy, out_valid}), 32'b100);
    checkOutput("end_cfg_err", 32'(cfg_err), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("done_clear", 32'(done), 32'd0);
    @(posedge clk); #1;

    checkOutput("exp_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("beat_count", 32'(got_bits.size()), 32'(nn));
    rx = '0;
    for (int i = 0; i < got_bits.size() && i < nn; i++) rx[i] = got_bits[i];
    rem = poly_reduce(rx, nn, pp, g);
    checkOutput("syndrome_zero", 32'(|rem), 32'd0);
  endtask

  initial begin : driver
    logic [1023:0] msg63;
    logic [1023:0] cw63;
    rst       = 1'b1;
    start     = 1'b0;
    n         = '0;
    t         = '0;
    m         = '0;
    g_poly    = '0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_outputs", 32'({in_ready, out_valid, out_bit, out_last, busy, done, cfg_err}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus("ham_1000", bits_from(64'b1000, 4), 7, 3, 1, G_HAM, bits_from(64'b1000101, 7), 1'b0, 1'b0, -1);
    applyStimulus("ham_1101", bits_from(64'b1101, 4), 7, 3, 1, G_HAM, bits_from(64'b1101001, 7), 1'b0, 1'b0, -1);

    msg63 = bits_from(64'h2D3C_9A1F_07E5_B16C, 51);
    cw63  = model_cw(msg63, 63, 12, G_63_51);
    applyStimulus("bch63_clean", msg63, 63, 6, 2, G_63_51, cw63, 1'b0, 1'b0, -1);
    applyStimulus("bch63_stall", msg63, 63, 6, 2, G_63_51, cw63, 1'b1, 1'b0, -1);

    start  = 1'b1;
    n      = 10'd12;
    m      = 4'd6;
    t      = 4'd2;
    g_poly = G_63_51;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("bad_cfg_flags", 32'({done, cfg_err, busy}), 32'b110);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("bad_cfg_hold", 32'({done, cfg_err, busy}), 32'b010);
    @(posedge clk); #1;
    applyStimulus("ham_after_bad", bits_from(64'b1000, 4), 7, 3, 1, G_HAM, bits_from(64'b1000101, 7), 1'b0, 1'b0, -1);

    applyStimulus("ham_reset_par", bits_from(64'b1101, 4), 7, 3, 1, G_HAM, bits_from(64'b1101001, 7), 1'b0, 1'b0, 1);
    applyStimulus("ham_after_rst", bits_from(64'b1101, 4), 7, 3, 1, G_HAM, bits_from(64'b1101001, 7), 1'b0, 1'b0, -1);

    applyStimulus("bch63_poke", msg63, 63, 6, 2, G_63_51, cw63, 1'b0, 1'b1, -1);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/bch_enc_core.md
# bch_enc_core

Bit-serial systematic BCH encoder; the transmit-side counterpart of the hard-decision BCH decoder core. Per frame it accepts a runtime code configuration (n, t, m) and a generator polynomial, streams the k = n − m·t message bits through unchanged, and then emits the m·t parity bits from a generator-polynomial LFSR. It sits between the payload source and the channel/modulation stage, and its codeword ordering matches what the decoder consumes in `hard_bits`.

## Interface
- `N_MAX`, 1023: maximum codeword length.
- `T_MAX`, 4: maximum correctable errors.
- `M_MAX`, 10: maximum GF(2^m) degree.
- `PAR_MAX`, M_MAX*T_MAX: parity register width.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; latches configuration and begins a frame.
- `n`  in  10  codeword length.
- `t`  in  4  error-correction capability.
- `m`  in  4  field degree.
- `g_poly`  in  PAR_MAX  generator coefficients. Bit i is the coefficient of x^i for i < m·t; the leading x^(m·t) term is implicit.
- `in_valid`  in  1  message bit valid.
- `in_ready`  out  1  encoder accepts a message bit.
- `in_bit`  in  1  message bit, highest-degree bit first.
- `out_valid`  out  1  codeword bit valid.
- `out_ready`  in  1  downstream accepts a codeword bit.
- `out_bit`  out  1  codeword bit.
- `out_last`  out  1  marks the final parity bit of the frame.
- `busy`  out  1  a frame is in progress.
- `done`  out  1  one-cycle pulse at the end of a frame or on a config rejection.
- `cfg_err`  out  1  the last `start` was rejected; holds until the next `start`.

## Operation
- Let p = m·t and k = n − p. These are computed when `start` is accepted and stay frozen for the frame.
- States are IDLE, MSG and PAR.
- **IDLE.** `start` is checked here; it is ignored in any other state.
  - Configuration is valid when all of the following hold: 3 ≤ m ≤ M_MAX; 1 ≤ t ≤ T_MAX; p < n; n ≤ 2^m − 1; n ≤ N_MAX; g_poly[0] = 1.
  - Invalid configuration: `done` = 1 and `cfg_err` = 1 on the next cycle; the block stays in IDLE.
  - Valid configuration: the LFSR and counter clear, `cfg_err` clears, and the next state is MSG.
- **MSG.** Pass-through: `out_valid` = `in_valid`, `in_ready` = `out_ready`, `out_bit` = `in_bit`. All three are combinational.
  - A beat occurs when `in_valid` and `out_ready` are both high.
  - On each beat: fb = in_bit ^ r[p−1]; r ← ((r << 1) ^ (fb ? g_poly : 0)) masked to p bits; cnt++.
  - After beat k, cnt clears and the next state is PAR.
- **PAR.** `in_ready` = 0, `out_valid` = 1, `out_bit` = r[p−1].
  - On each beat with `out_ready` high: r ← r << 1 (masked); cnt++.
  - `out_last` = 1 while cnt = p − 1.
  - After beat p, the next state is IDLE and `done` pulses on the following cycle.
- `busy` = 1 in MSG and PAR.

## Timing
- **Reset values:** state IDLE; r = 0; cnt = 0. Outputs `in_ready`, `out_valid`, `out_bit`, `out_last`, `busy`, `done` and `cfg_err` are all 0.
- **Reset mid-frame:** return to IDLE. No `done` is issued and the partial frame is discarded.
- **Start latency:** `start` at cycle c → MSG at c+1. `in_ready` can be high from c+1.
- **Message path:** zero-latency pass-through.
- **Frame length:** the MSG→PAR switch takes no bubble, so parity bit 0 can be presented on the cycle after the k-th beat. With no stalls, a frame takes 1 + n cycles plus the `done` cycle.
- **Stalls:** while `out_ready` is low, `out_bit` and `out_last` stay stable and r does not change.
- **Simultaneous events:** `start` arriving together with the last parity beat is ignored, because the state is not yet IDLE.
- **Widths:** cnt is 10 bits. The mask is (1 << p) − 1, and bits of r at or above p are always 0.

## Structure
- The shared package/include holds `N_MAX`, `T_MAX`, `M_MAX`, `PAR_MAX`, the state encodings, and the config-validity check function. The decoder core uses the same function.
- Sub-module `bch_par_lfsr`: a p-bit masked LFSR with `clr`, `shift`, `feed` (feedback enable) and `din`, producing `msb`. The FSM, counter and handshakes stay in the top level.

## Test plan
- **Hamming (7,4):** n=7, m=3, t=1, g_poly=…011; message 1000 → codeword 1000101. `out_last` is high on the 7th beat and `done` pulses on the cycle after.
- **Same code, second message:** message 1101 → codeword 1101001.
- **Random backpressure:** toggle `out_ready` at random with n=63, m=6, t=2, and g_poly taken from the decoder tables. The codeword must match the stall-free result, and re-encoding it into the decoder core must give syndrome 0 / `success` = 1.
- **Bad configuration:** `start` with m=6, t=2, n=12 (p = n) → `done` = 1 and `cfg_err` = 1 one cycle later, `busy` stays 0. A following valid `start` clears `cfg_err`.
- **Reset mid-frame:** assert `rst` during PAR → the next cycle shows all outputs 0 and state IDLE, with no `done`. A new frame then encodes correctly.
- **Ignored start:** pulse `start` while in MSG → no effect, and the current codeword is unchanged.
